input_conditioner_v1: RTL
=========================

# input_conditioner_v1

Synchronizes, debounces and edge-detects the board's raw `switch_array` and `button0..3` inputs before they reach the core top level. It exposes the conditioned levels directly and through a small four-word memory-mapped register window. The window holds sticky press flags and an interrupt mask. This block sits upstream of the processor top level.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes. Minimum 2.
- `clk` in 1: single clock; every register in this block is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `switch_array` in 16: raw, asynchronous switch levels.
- `button0`..`button3` in 1 each: raw, asynchronous, active-high when pressed.
- `mmio_addr` in 2: word index into the register window.
- `mmio_rd_en` in 1: read strobe.
- `mmio_wr_en` in 1: write strobe.
- `mmio_wr_data` in 32: write data.
- `mmio_rd_data` out 32: read data, registered.
- `mmio_rd_valid` out 1: high for one cycle when `mmio_rd_data` is valid.
- `switch_stable` out 16: debounced switch vector.
- `button_level` out 4: debounced button levels; bit i corresponds to `button<i>`.
- `button_pulse` out 4: one-cycle pulse on each debounced rising edge.
- `irq` out 1: registered; equals `|(press_flags & irq_enable)`.
- `io_error_vector` out 8: sticky diagnostic bits.

## Operation
- **Synchronizer.** Each of the 20 raw inputs passes through a two-flop synchronizer.
- **Button debounce.** Each button has its own counter and a two-state FSM: STABLE_LOW and STABLE_HIGH.
  - The counter increments on each cycle where the synchronized input differs from the current stable level.
  - Any cycle where they match clears the counter to 0.
  - When the counter would reach `DEBOUNCE_CYCLES`, the FSM toggles state and the counter clears.
- **Switch debounce.** The 16 switches are debounced as one vector with one shared counter.
  - The counter clears whenever the synchronized vector differs from its previous-cycle value, or when it equals `switch_stable`.
  - Otherwise the counter increments; `switch_stable` loads the synchronized vector when the count reaches `DEBOUNCE_CYCLES`.
- **Press pulse.** `button_pulse[i]` is high in the first cycle that `button_level[i]` reads 1. Falling edges produce no pulse.
- **Register window** (32-bit words):
  - addr 0: `{16'b0, switch_stable}`, read-only.
  - addr 1: `{28'b0, button_level}`, read-only.
  - addr 2: `{28'b0, press_flags}`, read / write-1-to-clear.
  - addr 3: `{28'b0, irq_enable}`, read/write; bits [3:0] only, upper bits ignored.
- **Press flags.** `press_flags[i]` sets on `button_pulse[i]`. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- **Reads.**
  - `mmio_rd_data` is zero whenever `mmio_rd_valid` is low.
  - With `mmio_rd_en` and `mmio_wr_en` both high, the write takes effect and the read returns the pre-write value.
- **Writes.** A write to addr 0 or addr 1 is ignored.
- **`io_error_vector`** bits, sticky until reset:
  - bit0: write to a read-only address.
  - bit1: simultaneous `mmio_rd_en` and `mmio_wr_en`.
  - bits [7:2]: always 0.

## Timing
- **Reset values.** On a rising edge with `rst` high, all of the following go to 0:
  - synchronizer flops, counters, debounce FSMs (to STABLE_LOW)
  - `switch_stable`, `button_level`, `button_pulse`
  - `press_flags`, `irq_enable`, `irq`
  - `mmio_rd_data`, `mmio_rd_valid`, `io_error_vector`
- **Reset mid-debounce** discards counter progress. `rst` overrides any MMIO access in the same cycle.
- **Input-to-level latency.** A raw input change sampled at edge k is visible at the synchronizer output after edge k+1. The stable level updates at edge k+1+`DEBOUNCE_CYCLES`, provided the input holds.
- **Pulse timing.** `button_pulse[i]` rises with `button_level[i]` and drops after exactly one cycle.
- **Flag and irq latency.**
  - `press_flags[i]` is 1 one cycle after the pulse.
  - `irq` is 1 one cycle after that.
- **Read latency.** `mmio_rd_en` at edge n gives valid data and `mmio_rd_valid` after edge n+1.
- **Write latency.** Write effects are visible one cycle after the write edge.
- **Glitch rejection.** Any synchronized glitch shorter than `DEBOUNCE_CYCLES` cycles causes no level change, no pulse and no flag.
- **Counter width.** Counters are wide enough for `DEBOUNCE_CYCLES` and saturate rather than wrap.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset.** Assert `rst` for 2 cycles with all raw inputs high, then deassert -> every output is 0 during reset. After release, `button_level` reaches 4'hF and `switch_stable` reaches 16'hFFFF at edge 5 after release.
2. **Clean press.** `button2` goes high before edge 0 and holds -> `button_level` = 4'b0100 after edge 5. `button_pulse[2]` is high for exactly one cycle, `press_flags` = 4'b0100 one cycle later, and `irq` stays 0 because `irq_enable` = 0.
3. **Chatter rejection.** `button0` toggles high 2 cycles, low 1, high 2, then low -> no change on `button_level`, `button_pulse` or `press_flags`.
4. **MMIO and irq.** Write 32'h0000000F to addr 3. Press `button1` -> `irq` = 1. Write 32'h2 to addr 2 -> `irq` = 0 and a read of addr 2 returns 32'h0, with `mmio_rd_valid` one cycle after `mmio_rd_en`.
5. **Set beats clear, and error bits.** Issue a W1C of 32'h1 on the same cycle `button_pulse[0]` fires -> `press_flags[0]` stays 1. Write addr 0 -> `io_error_vector` = 8'h01. Then assert rd and wr together -> 8'h03.
6. **Switch vector.** Set `switch_array` = 16'hA5A5, change it to 16'h5A5A after 3 cycles, then hold -> `switch_stable` never shows 16'hA5A5 and becomes 16'h5A5A 5 edges after the second change is sampled.

Source files
------------

// File: rtl/input_conditioner_v1_if.sv
// Memory-mapped register window bus for input_conditioner_v1.
//   mmio_addr     : word index into the four-word window
//   mmio_rd_en    : read strobe
//   mmio_wr_en    : write strobe
//   mmio_wr_data  : write data
//   mmio_rd_data  : registered read data, zero when mmio_rd_valid is low
//   mmio_rd_valid : one-cycle valid for mmio_rd_data
interface input_conditioner_v1_if;
  logic [1:0]  mmio_addr;
  logic        mmio_rd_en;
  logic        mmio_wr_en;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        mmio_rd_valid;

  modport master (
    output mmio_addr, mmio_rd_en, mmio_wr_en, mmio_wr_data,
    input  mmio_rd_data, mmio_rd_valid
  );

  modport slave (
    input  mmio_addr, mmio_rd_en, mmio_wr_en, mmio_wr_data,
    output mmio_rd_data, mmio_rd_valid
  );
endinterface

// File: rtl/input_conditioner_v1.sv
// Synchronizes, debounces and edge-detects the raw switch and button inputs,
// and exposes them through a four-word register window with sticky press
// flags and an interrupt mask.
//   clk, rst            : single clock, synchronous active-high reset
//   switch_array[15:0]  : raw asynchronous switch levels
//   button0..button3    : raw asynchronous buttons, active-high
//   mmio                : register window bus (slave side)
//   switch_stable       : debounced switch vector
//   button_level        : debounced button levels
//   button_pulse        : one-cycle pulse on each debounced rising edge
//   irq                 : registered |(press_flags & irq_enable)
//   io_error_vector     : sticky diagnostics (bit0 write to RO, bit1 rd+wr)
//
// Button FSM states:
//   state       | meaning
//   STABLE_LOW  | debounced button level is 0
//   STABLE_HIGH | debounced button level is 1
module input_conditioner_v1 #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             switch_array,
  input  logic                    button0,
  input  logic                    button1,
  input  logic                    button2,
  input  logic                    button3,
  input_conditioner_v1_if.slave   mmio,
  output logic [15:0]             switch_stable,
  output logic [3:0]              button_level,
  output logic [3:0]              button_pulse,
  output logic                    irq,
  output logic [7:0]              io_error_vector
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TC  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE_LOW = 1'b0, STABLE_HIGH = 1'b1} btn_state_e;

  logic [3:0]  btn_raw;
  logic [3:0]  btn_sync1, btn_sync2;
  logic [15:0] sw_sync1, sw_sync2;
  logic [CW-1:0] sw_cnt;

  btn_state_e    state_q [4];
  btn_state_e    state_d [4];
  logic [CW-1:0] cnt_q   [4];
  logic [CW-1:0] cnt_d   [4];
  logic [3:0]    pulse_d;

  logic [3:0]  press_flags;
  logic [3:0]  irq_enable;
  logic [1:0]  err_q;
  logic [3:0]  clr_mask;
  logic [31:0] rd_mux;

  assign btn_raw = {button3, button2, button1, button0};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      sw_sync1  <= switch_array;
      sw_sync2  <= sw_sync1;
    end
  end

  // Button debounce: per-button counter plus two-state FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= STABLE_LOW;
        cnt_q[i]   <= '0;
      end
      button_pulse <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      button_pulse <= pulse_d;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (btn_sync2[i] == (state_q[i] == STABLE_HIGH)) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_TC) begin
        // This cycle would be the DEBOUNCE_CYCLES-th mismatch: commit.
        cnt_d[i] = '0;
        case (state_q[i])
          STABLE_LOW: begin
            state_d[i] = STABLE_HIGH;
            pulse_d[i] = 1'b1;
          end
          STABLE_HIGH: state_d[i] = STABLE_LOW;
          default:     state_d[i] = STABLE_LOW;
        endcase
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      button_level[i] = (state_q[i] == STABLE_HIGH);
    end
  end

  // Switch debounce: one shared counter. A change is detected as it moves
  // between the synchronizer stages, which keeps the input-to-stable latency
  // identical to the buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cnt        <= '0;
      switch_stable <= '0;
    end else if ((sw_sync2 != sw_sync1) || (sw_sync2 == switch_stable)) begin
      sw_cnt <= '0;
    end else if (sw_cnt >= CNT_TC) begin
      switch_stable <= sw_sync2;
      sw_cnt        <= '0;
    end else if (sw_cnt != CNT_MAX) begin
      sw_cnt <= sw_cnt + CW'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (mmio.mmio_addr)
      2'd0: rd_mux = {16'b0, switch_stable};
      2'd1: rd_mux = {28'b0, button_level};
      2'd2: rd_mux = {28'b0, press_flags};
      2'd3: rd_mux = {28'b0, irq_enable};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (mmio.mmio_wr_en && (mmio.mmio_addr == 2'd2)) clr_mask = mmio.mmio_wr_data[3:0];
  end

  // Reads sample the pre-write state, so a simultaneous write is not visible
  // in the returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_flags        <= '0;
      irq_enable         <= '0;
      irq                <= 1'b0;
      mmio.mmio_rd_data  <= '0;
      mmio.mmio_rd_valid <= 1'b0;
      err_q              <= '0;
    end else begin
      press_flags <= (press_flags & ~clr_mask) | button_pulse;
      if (mmio.mmio_wr_en && (mmio.mmio_addr == 2'd3)) irq_enable <= mmio.mmio_wr_data[3:0];
      irq                <= |(press_flags & irq_enable);
      mmio.mmio_rd_valid <= mmio.mmio_rd_en;
      mmio.mmio_rd_data  <= mmio.mmio_rd_en ? rd_mux : 32'b0;
      if (mmio.mmio_wr_en && (mmio.mmio_addr < 2'd2)) err_q[0] <= 1'b1;
      if (mmio.mmio_wr_en && mmio.mmio_rd_en)         err_q[1] <= 1'b1;
    end
  end

  assign io_error_vector = {6'b0, err_q};

endmodule
